// File: rtl/fmps_pkg.sv
// -----------------------------------------------------------------------------
// fmps_pkg
// Shared definitions for the FMPS Aurora test-pattern generator:
//   - default header magic
//   - bit positions of the header and data-word fields
//   - FSM state encoding
//   - helpers that assemble the two beats of a test packet
// -----------------------------------------------------------------------------
package fmps_pkg;

  localparam logic [15:0] FMPS_HEADER_MAGIC = 16'hB6CF;

  // Header beat layout
  localparam int HDR_MAGIC_LSB = 16;
  localparam int HDR_INDEX_LSB = 10;

  // Data beat layout
  localparam int DATA_INVALID_FMPS2CC_BIT = 31;
  localparam int DATA_INVALID_CC2CC_BIT   = 30;
  localparam int DATA_RESERVED_BIT        = 29;
  localparam int DATA_INDEX_LSB           = 24;
  localparam int DATA_MAGIC_LSB           = 8;
  localparam int DATA_CYCLE_LSB           = 0;

  // Widest index the field layouts leave room for
  localparam int FMPS_MAX_INDEX_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } fmps_state_e;

  // Header: {magic, 1'b0, index, zeros}
  function automatic logic [31:0] fmps_header_word(
    input logic [15:0]                     magic,
    input logic [FMPS_MAX_INDEX_WIDTH-1:0] idx
  );
    logic [31:0] w;
    w = '0;
    w[HDR_MAGIC_LSB +: 16]                  = magic;
    w[HDR_INDEX_LSB +: FMPS_MAX_INDEX_WIDTH] = idx;
    return w;
  endfunction

  // Data: {invalid flags (always clear), index, magic, FA cycle}
  function automatic logic [31:0] fmps_data_word(
    input logic [FMPS_MAX_INDEX_WIDTH-1:0] idx,
    input logic [15:0]                     magic,
    input logic [7:0]                      cyc
  );
    logic [31:0] w;
    w = '0;
    w[DATA_INVALID_FMPS2CC_BIT]               = 1'b0;
    w[DATA_INVALID_CC2CC_BIT]                 = 1'b0;
    w[DATA_RESERVED_BIT]                      = 1'b0;
    w[DATA_INDEX_LSB +: FMPS_MAX_INDEX_WIDTH] = idx;
    w[DATA_MAGIC_LSB +: 16]                   = magic;
    w[DATA_CYCLE_LSB +: 8]                    = cyc;
    return w;
  endfunction

endpackage

// File: rtl/write_fmps_test_link_if.sv
// -----------------------------------------------------------------------------
// write_fmps_test_link_if
// AXI4-Stream TX bundle towards the Aurora user interface.
//   tdata  [31:0] stream data          (master -> slave)
//   tvalid        beat valid           (master -> slave)
//   tlast         last beat of packet  (master -> slave)
//   tready        sink ready           (slave  -> master)
// -----------------------------------------------------------------------------
interface write_fmps_test_link_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/write_fmps_test_link.sv
// -----------------------------------------------------------------------------
// write_fmps_test_link
// FMPS Aurora link test-pattern generator. Each packet request produces one
// two-beat AXI4-Stream packet (header, then data word carrying index, data
// magic and FA cycle count).
//
// Ports
//   auroraUserClk    in   sole clock
//   auroraUserReset  in   asynchronous active-high reset
//   csrStrobe        in   CSR write strobe
//   GPIO_OUT[31:0]   in   CSR write data, base index in [24 +: INDEX_WIDTH]
//   csr[31:0]        out  [31]=auroraChannelUp, [24 +: INDEX_WIDTH]=base index
//   genPacketStrobe  in   packet request (multi-packet mode)
//   auroraFAstrobe   in   FA cycle marker (request source in single mode)
//   auroraChannelUp  in   link up; gates all transmission
//   tx               master stream port (tdata/tvalid/tlast out, tready in)
// -----------------------------------------------------------------------------
module write_fmps_test_link
  import fmps_pkg::*;
#(
  parameter int          INDEX_WIDTH            = 5,
  parameter string       WITH_MULT_PACK_SUPPORT = "true",
  parameter logic [15:0] DATA_MAGIC             = 16'hCACA,
  parameter logic [15:0] HEADER_MAGIC           = FMPS_HEADER_MAGIC
) (
  input  logic                   auroraUserClk,
  input  logic                   auroraUserReset,
  input  logic                   csrStrobe,
  input  logic [31:0]            GPIO_OUT,
  output logic [31:0]            csr,
  input  logic                   genPacketStrobe,
  input  logic                   auroraFAstrobe,
  input  logic                   auroraChannelUp,
  write_fmps_test_link_if.master tx
);

  localparam bit MULT_PACK = (WITH_MULT_PACK_SUPPORT == "true");

  fmps_state_e             state_q, state_d;
  logic [INDEX_WIDTH-1:0]  base_index_q;
  logic [INDEX_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
  logic [7:0]              fa_cycle_q, fa_cycle_d;
  logic [7:0]              cyc_q, cyc_d;
  logic [3:0]              pending_q, pending_d;
  logic [31:0]             tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;

  logic                    req;
  logic                    slot_free;
  logic                    launch;
  logic [INDEX_WIDTH-1:0]  pkt_base;
  logic [INDEX_WIDTH-1:0]  launch_idx;
  logic [4:0]              pending_sum;
  logic                    unused_gpio;

  // Only the base-index slice of the write data is meaningful.
  assign unused_gpio = ^GPIO_OUT;

  // Requests seen while the channel is down are simply discarded.
  assign req = auroraChannelUp & (MULT_PACK ? genPacketStrobe : auroraFAstrobe);

  // A coinciding FA strobe takes effect before the launch samples the
  // counters, so the packet sees pktCnt=0 and the incremented cycle number.
  assign fa_cycle_d = auroraFAstrobe ? fa_cycle_q + 8'd1 : fa_cycle_q;
  assign pkt_base   = auroraFAstrobe ? '0 : pkt_cnt_q;
  assign launch_idx = base_index_q + pkt_base;

  // A new packet may start from IDLE, or on the cycle the data beat is
  // accepted so consecutive packets run without a gap.
  assign slot_free = (state_q == ST_IDLE) || ((state_q == ST_DATA) && tx.tready);
  assign launch    = auroraChannelUp && ((pending_q != 4'd0) || req) && slot_free;

  assign pkt_cnt_d = pkt_base + INDEX_WIDTH'(launch);

  // launch implies pending_q>0 or req, so the sum never underflows.
  assign pending_sum = {1'b0, pending_q} + 5'(req) - 5'(launch);

  always_comb begin
    pending_d = pending_q;
    if (!auroraChannelUp) begin
      pending_d = 4'd0;
    end else if (pending_sum > 5'd15) begin
      pending_d = 4'd15;
    end else begin
      pending_d = pending_sum[3:0];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cyc_d    = cyc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;

    if (!auroraChannelUp) begin
      // Link loss abandons whatever packet is in flight.
      state_d  = ST_IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else if (launch) begin
      state_d  = ST_HDR;
      idx_d    = launch_idx;
      cyc_d    = fa_cycle_d;
      tdata_d  = fmps_header_word(HEADER_MAGIC, FMPS_MAX_INDEX_WIDTH'(launch_idx));
      tvalid_d = 1'b1;
      tlast_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
        ST_HDR: begin
          if (tx.tready) begin
            state_d = ST_DATA;
            tdata_d = fmps_data_word(FMPS_MAX_INDEX_WIDTH'(idx_q), DATA_MAGIC, cyc_q);
            tlast_d = 1'b1;
          end
        end
        ST_DATA: begin
          if (tx.tready) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge auroraUserClk or posedge auroraUserReset) begin
    if (auroraUserReset) begin
      state_q      <= ST_IDLE;
      base_index_q <= '0;
      pkt_cnt_q    <= '0;
      idx_q        <= '0;
      fa_cycle_q   <= '0;
      cyc_q        <= '0;
      pending_q    <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_cnt_q  <= pkt_cnt_d;
      idx_q      <= idx_d;
      fa_cycle_q <= fa_cycle_d;
      cyc_q      <= cyc_d;
      pending_q  <= pending_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      if (csrStrobe) begin
        base_index_q <= GPIO_OUT[24 +: INDEX_WIDTH];
      end
    end
  end

  // Link status is reported live; the index field comes from its register.
  always_comb begin
    csr                      = '0;
    csr[31]                  = auroraChannelUp;
    csr[24 +: INDEX_WIDTH]   = base_index_q;
  end

  assign tx.tdata  = tdata_q;
  assign tx.tvalid = tvalid_q;
  assign tx.tlast  = tlast_q;

endmodule

// File: tb/tb_write_fmps_test_link.sv
module tb_write_fmps_test_link;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_strobe;
  logic [31:0] gpio;
  logic        gen_m, fa_m, up_m;
  logic        gen_s, fa_s, up_s;
  logic [31:0] csr_m, csr_s;

  always #5 clk = ~clk;

  write_fmps_test_link_if if_m ();
  write_fmps_test_link_if if_s ();

  write_fmps_test_link #(
    .INDEX_WIDTH(5), .WITH_MULT_PACK_SUPPORT("true"),
    .DATA_MAGIC(16'hCACA), .HEADER_MAGIC(16'hB6CF)
  ) dut_m (
    .auroraUserClk(clk), .auroraUserReset(rst),
    .csrStrobe(csr_strobe), .GPIO_OUT(gpio), .csr(csr_m),
    .genPacketStrobe(gen_m), .auroraFAstrobe(fa_m), .auroraChannelUp(up_m),
    .tx(if_m)
  );

  write_fmps_test_link #(
    .INDEX_WIDTH(5), .WITH_MULT_PACK_SUPPORT("false"),
    .DATA_MAGIC(16'hCACA), .HEADER_MAGIC(16'hB6CF)
  ) dut_s (
    .auroraUserClk(clk), .auroraUserReset(rst),
    .csrStrobe(csr_strobe), .GPIO_OUT(gpio), .csr(csr_s),
    .genPacketStrobe(gen_s), .auroraFAstrobe(fa_s), .auroraChannelUp(up_s),
    .tx(if_s)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: each accepted request becomes one packet whose index is
  // base + (packets requested since the last FA) and whose cycle byte is the
  // number of FA strobes seen so far. Packets leave in request order.
  typedef struct { logic [4:0] idx; logic [7:0] cyc; } pkt_t;
  pkt_t exp_q[$];
  int   base_m        = 0;
  int   fa_count_m    = 0;
  int   pkts_since_fa = 0;
  int   fa_count_s    = 0;
  int   tready_mode   = 0;   // 0: always ready, 1: random, 2: never ready

  function automatic logic [31:0] hdr_word(input int idx);
    return (32'hB6CF << 16) | (32'(idx & 31) << 10);
  endfunction

  function automatic logic [31:0] data_word(input int idx, input int cyc);
    return (32'(idx & 31) << 24) | (32'hCACA << 8) | 32'(cyc & 255);
  endfunction

  // Sink ready pattern, updated just after each active edge
  always @(posedge clk) begin
    #1;
    case (tready_mode)
      0:       if_m.tready = 1'b1;
      1:       if_m.tready = 1'($urandom_range(0, 1));
      default: if_m.tready = 1'b0;
    endcase
  end

  // Stream monitor for the multi-packet instance
  logic        in_pkt = 1'b0;
  logic        stalled = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;
  pkt_t        cur;

  always @(negedge clk) begin
    if (!rst) begin
      if (stalled && up_m) begin
        vectors++;
        if (!(if_m.tvalid === 1'b1 && if_m.tdata === stall_data && if_m.tlast === stall_last)) begin
          miscompares++;
          $display("FAIL hold_stable: got v=%0b d=%08h l=%0b, want v=1 d=%08h l=%0b",
                   if_m.tvalid, if_m.tdata, if_m.tlast, stall_data, stall_last);
        end
      end
      stalled    = if_m.tvalid && !if_m.tready && up_m;
      stall_data = if_m.tdata;
      stall_last = if_m.tlast;
      if (if_m.tvalid === 1'b1 && if_m.tready === 1'b1) begin
        vectors++;
        if (!in_pkt) begin
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_header: got %08h, want no packet", if_m.tdata);
            cur.idx = '0;
            cur.cyc = '0;
          end else begin
            cur = exp_q.pop_front();
            if (if_m.tdata !== hdr_word(int'(cur.idx)) || if_m.tlast !== 1'b0) begin
              miscompares++;
              $display("FAIL header: got %08h last=%0b, want %08h last=0",
                       if_m.tdata, if_m.tlast, hdr_word(int'(cur.idx)));
            end
          end
          in_pkt = 1'b1;
        end else begin
          if (if_m.tdata !== data_word(int'(cur.idx), int'(cur.cyc)) || if_m.tlast !== 1'b1) begin
            miscompares++;
            $display("FAIL data: got %08h last=%0b, want %08h last=1",
                     if_m.tdata, if_m.tlast, data_word(int'(cur.idx), int'(cur.cyc)));
          end
          $display("packet idx=%0d cyc=%0d data=%08h", cur.idx, cur.cyc, if_m.tdata);
          in_pkt = 1'b0;
        end
      end
      if (!up_m) in_pkt = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input int b);
    gpio       = ($urandom & 32'hE0FF_FFFF) | (32'(b & 31) << 24);
    csr_strobe = 1'b1;
    tick();
    csr_strobe = 1'b0;
    gpio       = $urandom;   // must not be captured without a strobe
    base_m     = b;
    vectors++;
    if (csr_m !== ({up_m, 31'b0} | (32'(b & 31) << 24))) begin
      miscompares++;
      $display("FAIL csr_readback: got %08h, want base %0d up %0b", csr_m, b, up_m);
    end
  endtask

  task automatic pulse_gen_m();
    pkt_t p;
    gen_m = 1'b1;
    if (up_m) begin
      p.idx = 5'((base_m + pkts_since_fa) & 31);
      p.cyc = 8'(fa_count_m & 255);
      exp_q.push_back(p);
      pkts_since_fa++;
    end
    tick();
    gen_m = 1'b0;
  endtask

  task automatic pulse_fa_m();
    fa_m = 1'b1;
    tick();
    fa_m = 1'b0;
    fa_count_m++;
    pkts_since_fa = 0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_q.size() == 0 && if_m.tvalid === 1'b0) done = 1;
      else tick();
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d packets outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (if_m.tvalid !== 1'b0 || if_m.tlast !== 1'b0 || if_m.tdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_stream: got v=%0b l=%0b d=%08h, want 0/0/0",
               if_m.tvalid, if_m.tlast, if_m.tdata);
    end
    vectors++;
    if (csr_m !== 32'h0 || csr_s !== 32'h0 || if_s.tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_csr: got %08h/%08h v_s=%0b, want 0/0/0", csr_m, csr_s, if_s.tvalid);
    end
    $display("reset done");
  endtask

  task automatic test_channel_down();
    csr_write(1);
    pulse_fa_m();
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) pulse_gen_m();
      else tick();
      vectors++;
      if (if_m.tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL down_no_tx: got tvalid=%0b, want 0", if_m.tvalid);
      end
    end
    $display("channel-down requests discarded");
  endtask

  task automatic test_stream();
    up_m = 1'b1;
    tready_mode = 0;
    tick();
    tick();
    vectors++;
    if (csr_m !== 32'h8100_0000) begin
      miscompares++;
      $display("FAIL csr_up: got %08h, want 81000000", csr_m);
    end
    pulse_fa_m();
    for (int i = 0; i < 8; i++) begin
      pulse_gen_m();
      vectors++;
      if (if_m.tvalid !== 1'b1 || if_m.tdata !== hdr_word(base_m + i)) begin
        miscompares++;
        $display("FAIL req_latency: got v=%0b d=%08h, want v=1 d=%08h",
                 if_m.tvalid, if_m.tdata, hdr_word(base_m + i));
      end
      repeat (8) tick();
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    tready_mode = 1;
    for (int r = 0; r < 2; r++) begin
      pulse_fa_m();
      for (int i = 0; i < 8; i++) begin
        pulse_gen_m();
        repeat (8) tick();
      end
      wait_drain();
    end
    tready_mode = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    pulse_fa_m();
    for (int k = 1; k <= 8; k++) begin
      if (k <= 4) pulse_gen_m();
      else tick();
      vectors++;
      if (if_m.tvalid !== 1'b1 || if_m.tlast !== 1'((k % 2) == 0)) begin
        miscompares++;
        $display("FAIL back_to_back beat %0d: got v=%0b l=%0b, want v=1 l=%0b",
                 k, if_m.tvalid, if_m.tlast, (k % 2) == 0);
      end
    end
    tick();
    vectors++;
    if (if_m.tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_end: got tvalid=%0b, want 0", if_m.tvalid);
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    csr_write(30);
    pulse_fa_m();
    for (int i = 0; i < 4; i++) begin
      pulse_gen_m();
      repeat (8) tick();
    end
    wait_drain();
  endtask

  task automatic test_channel_drop();
    int first_idx;
    tready_mode = 2;
    tick();
    first_idx = (base_m + pkts_since_fa) & 31;
    repeat (3) pulse_gen_m();
    vectors++;
    if (if_m.tvalid !== 1'b1 || if_m.tlast !== 1'b0 || if_m.tdata !== hdr_word(first_idx)) begin
      miscompares++;
      $display("FAIL stalled_header: got v=%0b l=%0b d=%08h, want v=1 l=0 d=%08h",
               if_m.tvalid, if_m.tlast, if_m.tdata, hdr_word(first_idx));
    end
    up_m = 1'b0;
    tick();
    exp_q.delete();
    vectors++;
    if (if_m.tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: got tvalid=%0b, want 0", if_m.tvalid);
    end
    up_m = 1'b1;
    tready_mode = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (if_m.tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL pending_cleared: got tvalid=%0b, want 0", if_m.tvalid);
      end
    end
    pulse_fa_m();
    pulse_gen_m();
    wait_drain();
    $display("channel drop recovered");
  endtask

  task automatic test_single_pack();
    up_s = 1'b1;
    tick();
    vectors++;
    if (csr_s !== ({1'b1, 31'b0} | (32'(base_m & 31) << 24))) begin
      miscompares++;
      $display("FAIL csr_single: got %08h, want base %0d up 1", csr_s, base_m);
    end
    for (int i = 0; i < 6; i++) begin
      gen_s = (i % 2 == 0);
      tick();
      gen_s = 1'b0;
      vectors++;
      if (if_s.tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL gen_ignored: got tvalid=%0b, want 0", if_s.tvalid);
      end
    end
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(2, 6)) tick();
      fa_s = 1'b1;
      tick();
      fa_s = 1'b0;
      fa_count_s++;
      vectors++;
      if (if_s.tvalid !== 1'b1 || if_s.tlast !== 1'b0 || if_s.tdata !== hdr_word(base_m)) begin
        miscompares++;
        $display("FAIL single_header: got v=%0b l=%0b d=%08h, want v=1 l=0 d=%08h",
                 if_s.tvalid, if_s.tlast, if_s.tdata, hdr_word(base_m));
      end
      tick();
      vectors++;
      if (if_s.tvalid !== 1'b1 || if_s.tlast !== 1'b1 ||
          if_s.tdata !== data_word(base_m, fa_count_s)) begin
        miscompares++;
        $display("FAIL single_data: got v=%0b l=%0b d=%08h, want v=1 l=1 d=%08h",
                 if_s.tvalid, if_s.tlast, if_s.tdata, data_word(base_m, fa_count_s));
      end
      tick();
      vectors++;
      if (if_s.tvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL single_one_packet: got tvalid=%0b, want 0", if_s.tvalid);
      end
      $display("single packet idx=%0d cyc=%0d", base_m, fa_count_s);
    end
  endtask

  initial begin
    rst         = 1'b1;
    csr_strobe  = 1'b0;
    gpio        = '0;
    gen_m       = 1'b0;
    fa_m        = 1'b0;
    up_m        = 1'b0;
    gen_s       = 1'b0;
    fa_s        = 1'b0;
    up_s        = 1'b0;
    if_m.tready = 1'b1;
    if_s.tready = 1'b1;

    test_reset();
    test_channel_down();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_channel_drop();
    test_single_pack();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
